// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive byte FIFO draining uart_rx into a first-word-fall-through
//            CPU read port, with fill-level back-pressure and status flags.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     cpu_clk,
  input  logic                     rstn,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_read,
  input  logic                     cpu_rd,
  input  logic                     cpu_flush,
  output logic [7:0]               rd_data,
  output logic                     not_empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK    = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            underflow_q, underflow_d;
  logic            rx_read_q, rx_read_d;
  logic [7:0]      mem [DEPTH];

  logic            is_empty;
  logic            is_full;
  logic            push;
  logic            pop;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  // Flush wins over both ports; the full check uses the pre-edge count so a
  // same-cycle pop never lets a push overrun the array.
  assign push = (state_q == ST_IDLE) && rx_valid && !is_full && !cpu_flush;
  assign pop  = cpu_rd && !is_empty && !cpu_flush;

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    rx_read_d   = push;

    case (state_q)
      ST_IDLE:   if (push) state_d = ST_ACK;
      ST_ACK:    state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (cpu_flush) begin
      wp_d        = '0;
      rp_d        = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (cpu_rd && is_empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      rx_read_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      rx_read_q   <= rx_read_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge cpu_clk) begin
    if (push) mem[wp_q] <= rx_data;
  end

  assign rd_data     = is_empty ? 8'h00 : mem[rp_q];
  assign not_empty   = !is_empty;
  assign full        = is_full;
  assign almost_full = (count_q >= AF_C);
  assign underflow   = underflow_q;
  assign count       = count_q;
  assign rx_read     = rx_read_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo (DEPTH=16, AF=12).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo;

  logic       cpu_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_read;
  logic       cpu_rd = 1'b0;
  logic       cpu_flush = 1'b0;
  logic [7:0] rd_data;
  logic       not_empty;
  logic       full;
  logic       almost_full;
  logic       underflow;
  logic [4:0] count;

  int total = 0;
  int bad = 0;

  uart_rx_fifo #(.DEPTH(16), .AF_LEVEL(12)) dut (
    .cpu_clk     (cpu_clk),
    .rstn        (rstn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_read     (rx_read),
    .cpu_rd      (cpu_rd),
    .cpu_flush   (cpu_flush),
    .rd_data     (rd_data),
    .not_empty   (not_empty),
    .full        (full),
    .almost_full (almost_full),
    .underflow   (underflow),
    .count       (count)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Presents one byte like uart_rx would and waits (bounded) for its ack,
  // then lets the ACK/SETTLE sequence complete.
  task automatic push_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rx_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    rx_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    total++; if (rx_read !== 1'b0) begin bad++; $display("FAIL reset_rx_read got=%b exp=0", rx_read); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({not_empty, full, almost_full, underflow} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags got=%b exp=0000", {not_empty, full, almost_full, underflow}); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    int pulses = 0;
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    tick();
    if (rx_read === 1'b1) pulses++;
    total++; if (rx_read !== 1'b1) begin bad++; $display("FAIL single_rx_read got=%b exp=1", rx_read); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    total++; if (rd_data !== 8'h41) begin bad++; $display("FAIL single_rd_data got=%h exp=41", rd_data); end
    total++; if (not_empty !== 1'b1) begin bad++; $display("FAIL single_not_empty got=%b exp=1", not_empty); end
    rx_data = 8'h42;
    tick();
    if (rx_read === 1'b1) pulses++;
    tick();
    if (rx_read === 1'b1) pulses++;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL single_ignore_count got=%0d exp=1", count); end
    total++; if (pulses != 1) begin bad++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    rx_valid = 1'b0;
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    total++; if (count !== 5'd0 || rd_data !== 8'h00) begin bad++;
      $display("FAIL single_pop got count=%0d data=%h exp count=0 data=00", count, rd_data); end
  endtask

  task automatic test_fill_to_full();
    bit ok;
    int pulses = 0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i), ok);
      total++; if (!ok || count !== 5'(i + 1)) begin bad++;
        $display("FAIL fill_push%0d got ok=%b count=%0d exp ok=1 count=%0d", i, ok, count, i + 1); end
      if (i == 10) begin
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL fill_af_at11 got=%b exp=0", almost_full); end
      end
      if (i == 11) begin
        total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL fill_af_at12 got=%b exp=1", almost_full); end
      end
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    rx_data  = 8'h10;
    rx_valid = 1'b1;
    repeat (5) begin
      tick();
      if (rx_read === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL fill_no_ack_when_full got=%0d exp=0", pulses); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL fill_head got=%h exp=00", rd_data); end
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rx_read === 1'b1) begin ok = 1'b1; break; end
    end
    total++; if (!ok || count !== 5'd16) begin bad++;
      $display("FAIL fill_resume got ack=%b count=%0d exp ack=1 count=16", ok, count); end
    rx_valid = 1'b0;
    tick();
    tick();
    for (int i = 1; i <= 16; i++) begin
      total++; if (rd_data !== 8'(i)) begin bad++; $display("FAIL fill_drain%0d got=%h exp=%h", i, rd_data, 8'(i)); end
      cpu_rd = 1'b1;
      tick();
      cpu_rd = 1'b0;
    end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL fill_drained got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    bit ok;
    push_byte(8'h80, ok);
    q.push_back(8'h80);
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(8'h81 + i), ok);
      q.push_back(8'(8'h81 + i));
      total++; if (!ok || count !== 5'(q.size()) || count > 5'd2) begin bad++;
        $display("FAIL wrap_count%0d got ok=%b count=%0d exp ok=1 count=%0d", i, ok, count, q.size()); end
      total++; if (rd_data !== q[0]) begin bad++; $display("FAIL wrap_data%0d got=%h exp=%h", i, rd_data, q[0]); end
      cpu_rd = 1'b1;
      tick();
      cpu_rd = 1'b0;
      void'(q.pop_front());
    end
    total++; if (rd_data !== q[0]) begin bad++; $display("FAIL wrap_last got=%h exp=%h", rd_data, q[0]); end
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i), ok);
    total++; if (count !== 5'd5) begin bad++; $display("FAIL b2b_pre got=%0d exp=5", count); end
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    cpu_rd   = 1'b1;
    tick();
    cpu_rd   = 1'b0;
    rx_valid = 1'b0;
    total++; if (rx_read !== 1'b1 || count !== 5'd5) begin bad++;
      $display("FAIL b2b_count got ack=%b count=%0d exp ack=1 count=5", rx_read, count); end
    total++; if (rd_data !== 8'hA1) begin bad++; $display("FAIL b2b_head got=%h exp=a1", rd_data); end
    tick();
    tick();
    cpu_flush = 1'b1;
    tick();
    cpu_flush = 1'b0;
    total++; if (count !== 5'd0 || rd_data !== 8'h00) begin bad++;
      $display("FAIL b2b_flush got count=%0d data=%h exp 0/00", count, rd_data); end
  endtask

  task automatic test_empty_read();
    bit ok;
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    total++; if (underflow !== 1'b1 || count !== 5'd0 || rd_data !== 8'h00) begin bad++;
      $display("FAIL empty_rd got uf=%b count=%0d data=%h exp 1/0/00", underflow, count, rd_data); end
    tick();
    tick();
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL empty_sticky got=%b exp=1", underflow); end
    push_byte(8'h55, ok);
    total++; if (!ok || count !== 5'd1 || rd_data !== 8'h55) begin bad++;
      $display("FAIL empty_ptr got ok=%b count=%0d data=%h exp 1/1/55", ok, count, rd_data); end
    cpu_flush = 1'b1;
    cpu_rd    = 1'b1;
    tick();
    cpu_flush = 1'b0;
    cpu_rd    = 1'b0;
    total++; if (underflow !== 1'b0 || count !== 5'd0) begin bad++;
      $display("FAIL empty_flush got uf=%b count=%0d exp 0/0", underflow, count); end
    cpu_flush = 1'b1;
    cpu_rd    = 1'b1;
    tick();
    cpu_flush = 1'b0;
    cpu_rd    = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL empty_flush_rd got uf=%b exp=0", underflow); end
  endtask

  task automatic test_flush_during_push();
    bit ok;
    push_byte(8'h11, ok);
    rx_data   = 8'h66;
    rx_valid  = 1'b1;
    cpu_flush = 1'b1;
    tick();
    cpu_flush = 1'b0;
    total++; if (rx_read !== 1'b0 || count !== 5'd0) begin bad++;
      $display("FAIL flushpush_suppress got ack=%b count=%0d exp 0/0", rx_read, count); end
    tick();
    rx_valid = 1'b0;
    total++; if (rx_read !== 1'b1 || count !== 5'd1 || rd_data !== 8'h66) begin bad++;
      $display("FAIL flushpush_retry got ack=%b count=%0d data=%h exp 1/1/66", rx_read, count, rd_data); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_ack();
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rstn = 1'b0;
    tick();
    total++; if (rx_read !== 1'b0 || count !== 5'd0 || rd_data !== 8'h00) begin bad++;
      $display("FAIL rst_ack got ack=%b count=%0d data=%h exp 0/0/00", rx_read, count, rd_data); end
    rstn = 1'b1;
    tick();
    rx_data  = 8'h78;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    total++; if (rx_read !== 1'b1 || rd_data !== 8'h78) begin bad++;
      $display("FAIL rst_idle got ack=%b data=%h exp 1/78", rx_read, rd_data); end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_to_full();
    test_wrap();
    test_back_to_back();
    test_empty_read();
    test_flush_during_push();
    test_reset_mid_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte FIFO between the `uart_rx` deserialiser and the CPU peripheral bus at offsets 0x10 (data) and 0x14 (status). It drains each byte from `uart_rx`'s single holding register into a DEPTH-entry buffer, which stops bytes being lost while firmware is busy. It presents a first-word-fall-through read port and status flags to the peripheral read mux. It raises an RTS-style back-pressure signal at a programmable fill level.

## Interface
- DEPTH, 16, FIFO entries; power of two, 4..256
- AF_LEVEL, 12, count at or above which `almost_full` asserts; 1..DEPTH
- cpu_clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low; clock cpu_clk
- rx_valid  in  1  `uart_rx` holding register has a byte
- rx_data  in  8  byte from `uart_rx`; stable while rx_valid
- rx_read  out  1  one-cycle pop strobe to `uart_rx`
- cpu_rd  in  1  one-cycle pop strobe; top drives it as peri read of 0x10, first cycle only
- cpu_flush  in  1  one-cycle flush strobe; write of bit0=1 to 0x14
- rd_data  out  8  head byte; 0x00 when empty
- not_empty  out  1  count != 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- underflow  out  1  sticky: cpu_rd seen while empty
- count  out  $clog2(DEPTH)+1  current fill level

## Operation
- Storage: DEPTH x 8 register array. Write pointer wp and read pointer rp are log2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked separately, range 0..DEPTH.
- Ingest FSM states:
  - IDLE: if rx_valid && !full && !cpu_flush, write rx_data to mem[wp], increment wp, register rx_read<=1, go to ACK.
  - ACK: rx_read is high for this cycle only. Go to SETTLE.
  - SETTLE: rx_valid is ignored because `uart_rx` is still clearing it. Go to IDLE.
- Sustained ingest is therefore at most 1 byte per 3 cycles, far above 115200 baud at 24 MHz.
- When full, the byte stays in `uart_rx`. No rx_read is issued, and `uart_rx` applies its own RTS/drop policy. Ingest resumes in IDLE once count < DEPTH.
- Pop: cpu_rd with count!=0 increments rp.
- Underflow: cpu_rd with count==0 leaves rp and count unchanged and sets underflow.
- Simultaneous push and pop in the same edge: count is unchanged and both pointers advance. A push into a full FIFO cannot occur, because the full check uses the pre-edge count.
- Flush: on cpu_flush, wp<=0, rp<=0, count<=0, underflow<=0.
  - Any push evaluated in the same cycle is suppressed and rx_read is not raised.
  - A cpu_rd in the same cycle is ignored and does not set underflow.
  - The FSM continues its current ACK/SETTLE sequence and does not reset.
- rd_data = mem[rp] when count!=0, else 0x00. It is combinational from registered state.
- Array contents are not reset. Only pointers, count, flags and FSM are reset.

## Timing
- Reset values:
  - rx_read=0, FSM=IDLE
  - count=0, not_empty=0, full=0, almost_full=0, underflow=0
  - rd_data=0x00
- Reset mid-operation:
  - Mid-ACK: rx_read drops on the reset edge, and the byte in `uart_rx` is already stored but then discarded with the rest of the FIFO.
  - Mid-SETTLE: the FSM returns to IDLE.
  - `uart_rx` resets on the same rstn.
- Push latency: rx_valid sampled high in IDLE at edge N. rd_data, not_empty and count reflect the byte after edge N. rx_read is high during cycle N..N+1. The FSM is in IDLE again after edge N+2.
- Pop latency: cpu_rd at edge N. rd_data shows the next entry after edge N. The CPU samples rd_data in the cycle cpu_rd is high, i.e. the current head.
- Flags derive from registered count. There is no additional latency beyond count.

## Test plan
- Single byte: rx_valid=1, rx_data=0x41 in IDLE -> rx_read pulses exactly once, 1 cycle wide. rd_data=0x41, count=1, not_empty=1 one edge after sampling. The FSM ignores rx_valid for 2 cycles.
- Fill to full (DEPTH=16): feed bytes 0x00..0x10 -> 16 bytes accepted and full=1. almost_full=1 from count=12. The 17th byte (0x10) gets no rx_read while full. One cpu_rd (returns 0x00) -> 0x10 is ingested within 3 cycles.
- Wrap-around: 40 push/pop cycles with an incrementing pattern -> read order matches write order across pointer wrap, and count never exceeds 2.
- Simultaneous push and pop at count=5 -> count stays 5, and the head advances to the next byte.
- Empty read: cpu_rd with count=0 -> rd_data=0x00, underflow=1 and sticky, pointers unchanged. cpu_flush -> underflow=0.
- Flush during push: cpu_flush coincident with rx_valid in IDLE -> no rx_read, count=0. The byte is ingested on the next IDLE cycle, giving count=1.
